// File: rtl/alu_issue_capture.sv
// rtl/alu_issue_capture.sv - operand issue register and result capture FIFO around a combinational alu
// Operands are registered into the alu; its result and flags are captured one cycle later.
module alu_issue_capture #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_x,
   input  logic [WIDTH-1:0]         in_y,
   output logic [WIDTH-1:0]         alu_x,
   output logic [WIDTH-1:0]         alu_y,
   input  logic [WIDTH-1:0]         alu_z,
   input  logic                     alu_sign,
   input  logic                     alu_zero,
   input  logic                     alu_carry,
   input  logic                     alu_parity,
   input  logic                     alu_overflow,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_z,
   output logic [4:0]               out_flags,
   output logic [4:0]               sticky_flags,
   input  logic                     sticky_clr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_alu_x;
   logic [WIDTH-1:0] r_alu_y;
   logic             r_pending;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [4:0]       r_sticky;
   logic [WIDTH-1:0] r_mem_z [DEPTH];
   logic [4:0]       r_mem_f [DEPTH];

   logic [4:0]       w_flags;
   logic [CW:0]      w_occupancy;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;

   assign w_flags     = {alu_overflow, alu_parity, alu_carry, alu_zero, alu_sign};
   // The pending capture counts against capacity so a push can never overflow.
   assign w_occupancy = {1'b0, r_count} + (CW + 1)'(r_pending);
   assign in_ready    = (w_occupancy < LP_DEPTH);
   assign w_accept    = in_valid && in_ready;
   assign w_push      = r_pending;
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_x   <= '0;
         r_alu_y   <= '0;
         r_pending <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_sticky  <= '0;
      end else begin
         r_pending <= w_accept;
         if (w_accept) begin
            r_alu_x <= in_x;
            r_alu_y <= in_y;
         end
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
         // A clear drops history but keeps whatever is captured on the same edge.
         if (sticky_clr) begin
            r_sticky <= w_push ? w_flags : 5'b0;
         end else if (w_push) begin
            r_sticky <= r_sticky | w_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_z[r_wptr] <= alu_z;
         r_mem_f[r_wptr] <= w_flags;
      end
   end

   assign alu_x        = r_alu_x;
   assign alu_y        = r_alu_y;
   assign out_valid    = w_out_valid;
   assign out_z        = w_out_valid ? r_mem_z[r_rptr] : '0;
   assign out_flags    = w_out_valid ? r_mem_f[r_rptr] : 5'b0;
   assign sticky_flags = r_sticky;
   assign count        = r_count;

endmodule

// File: tb/tb_alu_issue_capture.sv
// tb/tb_alu_issue_capture.sv - directed bench for alu_issue_capture with an adder model as the alu
module tb_alu_issue_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [15:0] alu_z;
   logic        alu_sign, alu_zero, alu_carry, alu_parity, alu_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_z;
   logic [4:0]  out_flags;
   logic [4:0]  sticky_flags;
   logic        sticky_clr;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_capture #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
      .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_parity(alu_parity), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count)
   );

   // Reference alu: 16-bit add; returns {overflow, parity, carry, zero, sign, z}
   function automatic logic [20:0] alu_ref(input logic [15:0] x, input logic [15:0] y);
      logic [16:0] s;
      logic        ov;
      s  = {1'b0, x} + {1'b0, y};
      ov = (x[15] == y[15]) && (s[15] != x[15]);
      return {ov, ^s[15:0], s[16], (s[15:0] == 16'h0), s[15], s[15:0]};
   endfunction

   always_comb begin
      {alu_overflow, alu_parity, alu_carry, alu_zero, alu_sign, alu_z} = alu_ref(alu_x, alu_y);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [20:0] q[$];
   logic [20:0] exp_head;
   int          m_count, m_pending, issued, popped;
   logic [15:0] m_px, m_py;
   logic        exp_rdy, acc, pop;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
      out_ready = 1'b1; sticky_clr = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_alu_x", alu_x, 0);
      chk("rst_sticky", sticky_flags, 0);
      rst_n = 1'b1;

      // single op: latency and flags
      in_valid = 1'b1; in_x = 16'h8fff; in_y = 16'h8000;
      step();
      in_valid = 1'b0;
      chk("t1_alu_x", alu_x, 16'h8fff);
      chk("t1_alu_y", alu_y, 16'h8000);
      chk("t1_not_yet", out_valid, 0);
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_z", out_z, 16'h0fff);
      chk("t1_flags", out_flags, 5'b10100);
      chk("t1_sticky", sticky_flags, 5'b10100);
      step();
      chk("t1_drained", out_valid, 0);
      chk("t1_z_masked", out_z, 0);
      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      chk("t5_clr_alone", sticky_flags, 0);

      // back-to-back
      in_valid = 1'b1; in_x = 16'hfffe; in_y = 16'h0002;
      step();
      in_x = 16'haaaa; in_y = 16'h5555;
      step();
      in_valid = 1'b0;
      chk("t2_z0", out_z, 16'h0000);
      chk("t2_f0", out_flags, 5'b00110);
      step();
      chk("t2_v1", out_valid, 1);
      chk("t2_z1", out_z, 16'hffff);
      chk("t2_f1", out_flags, 5'b00001);
      step();
      chk("t2_drained", out_valid, 0);
      chk("t2_sticky", sticky_flags, 5'b00111);

      // clear on the capture edge keeps only the new flags
      in_valid = 1'b1; in_x = 16'hfffe; in_y = 16'h0002;
      step();
      in_valid = 1'b0; sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      chk("t5_clr_push", sticky_flags, 5'b00110);
      chk("t5_z", out_z, 16'h0000);
      step();

      // fill with out_ready low
      out_ready = 1'b0; in_valid = 1'b1; in_y = 16'h0001;
      in_x = 16'h0100; step();
      in_x = 16'h0200; step();
      in_x = 16'h0300; step();
      in_x = 16'h0400; step();
      chk("t3_ready_pending", in_ready, 0);
      chk("t3_count3", count, 3);
      step();
      chk("t3_count4", count, 4);
      chk("t3_head", out_z, 16'h0101);
      step();
      chk("t3_hold4", count, 4);
      chk("t3_still_full", in_ready, 0);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_ready_back", in_ready, 1);
      chk("t3_count_pop", count, 3);
      in_valid = 1'b1; in_x = 16'h0500;
      step();
      in_valid = 1'b0;
      chk("t3_fifth_pending", in_ready, 0);
      step();
      chk("t3_count_wrap", count, 4);
      out_ready = 1'b1;
      chk("t3_o2", out_z, 16'h0201); step();
      chk("t3_o3", out_z, 16'h0301); step();
      chk("t3_o4", out_z, 16'h0401); step();
      chk("t3_o5", out_z, 16'h0501); step();
      chk("t3_empty", out_valid, 0);

      // scoreboarded stream: fill to full, then continuous push/pop
      m_count = 0; m_pending = 0; issued = 0; popped = 0; m_px = '0; m_py = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (issued == 10 && m_pending == 0 && m_count == 0) break;
         in_valid  = (issued < 10);
         out_ready = (cyc >= 6);
         in_x = 16'h2000 + 16'(issued) * 16'h0111;
         in_y = 16'h0003;
         exp_rdy = (m_count + m_pending) < 4;
         chk("t4_ready", in_ready, exp_rdy);
         chk("t4_count", count, m_count);
         acc = in_valid && exp_rdy;
         pop = out_ready && (m_count != 0);
         if (pop) begin
            exp_head = q.pop_front();
            chk("t4_z", out_z, exp_head[15:0]);
            chk("t4_flags", out_flags, exp_head[20:16]);
            popped++;
         end
         step();
         if (m_pending != 0) q.push_back(alu_ref(m_px, m_py));
         m_count = m_count + m_pending - (pop ? 1 : 0);
         m_pending = acc ? 1 : 0;
         if (acc) begin
            m_px = in_x; m_py = in_y; issued++;
         end
      end
      chk("t4_popped", popped, 10);
      chk("t4_final_empty", out_valid, 0);

      // reset with one pending and two stored
      out_ready = 1'b0; in_valid = 1'b1; in_y = 16'h0000;
      in_x = 16'h0a00; step();
      in_x = 16'h0b00; step();
      in_x = 16'h0c00; step();
      chk("t6_pre_count", count, 2);
      rst_n = 1'b0;
      #1;
      chk("t6_count", count, 0);
      chk("t6_valid", out_valid, 0);
      chk("t6_z", out_z, 0);
      chk("t6_flags", out_flags, 0);
      chk("t6_ready", in_ready, 1);
      chk("t6_alu_x", alu_x, 0);
      chk("t6_sticky", sticky_flags, 0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      in_valid = 1'b1; in_x = 16'h1234; in_y = 16'h0001; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("t6_first_v", out_valid, 1);
      chk("t6_first_z", out_z, 16'h1235);
      chk("t6_first_f", out_flags, 5'b00000);
      step();
      chk("t6_no_stale", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
